// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - architectural PC register with request/ack instruction fetch
//
// Holds the PC, fetches the instruction at PC from instruction memory and
// offers it to decode, advancing PC to pc_next on the decode handshake.
// Handles flush redirects, stall, halt and misaligned-target trapping.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   pc_next               next PC from the PC input adapter
//   pc, pc_plus4          current PC register and its wrap-around successor
//   imem_req, imem_addr   registered fetch request / address (held until ack)
//   imem_ack, imem_rdata  memory response, one ack per request
//   instr, instr_valid    captured instruction offered to decode
//   instr_ready           decode accepts instr this cycle
//   stall, halt           block advance / stop fetching after this instruction
//   flush, flush_pc       redirect PC (ignored once halted)
//   halted, addr_err      halted state flag, sticky misaligned-target flag
module pc_fetch_unit #(
  parameter int                   ADDR_BITS = 32,
  parameter logic [ADDR_BITS-1:0] RESET_PC  = {ADDR_BITS{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] pc_next,
  output logic [ADDR_BITS-1:0] pc,
  output logic [ADDR_BITS-1:0] pc_plus4,
  output logic                 imem_req,
  output logic [ADDR_BITS-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 flush,
  input  logic [ADDR_BITS-1:0] flush_pc,
  output logic                 halted,
  output logic                 addr_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_t;

  state_t               state;
  logic                 discard;    // in-flight response belongs to a flushed path
  logic                 advance;
  logic                 flush_mis;
  logic                 next_mis;
  logic [ADDR_BITS-1:0] flush_al;
  logic [ADDR_BITS-1:0] next_al;

  assign pc_plus4  = pc + ADDR_BITS'(4);
  assign advance   = (state == HOLD) && instr_valid && instr_ready && !stall;
  assign flush_mis = |flush_pc[1:0];
  assign next_mis  = |pc_next[1:0];
  assign flush_al  = {flush_pc[ADDR_BITS-1:2], 2'b00};
  assign next_al   = {pc_next[ADDR_BITS-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      addr_err    <= 1'b0;
      discard     <= 1'b0;
      state       <= IDLE;
    end else if (flush && state != HALTED) begin
      // Flush wins over advance and stall.
      instr_valid <= 1'b0;
      if (flush_mis) begin
        pc       <= flush_al;
        addr_err <= 1'b1;
        halted   <= 1'b1;
        imem_req <= 1'b0;
        discard  <= 1'b0;
        state    <= HALTED;
      end else begin
        pc <= flush_pc;
        if (state == FETCH && !imem_ack) begin
          // Request must stay stable until acked; drop its data later and
          // refetch from whatever pc holds at that point.
          discard <= 1'b1;
        end else begin
          // Any same-cycle response is simply not captured.
          discard   <= 1'b0;
          imem_req  <= 1'b1;
          imem_addr <= flush_pc;
          state     <= FETCH;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          imem_req  <= 1'b1;
          imem_addr <= pc;
          state     <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            if (discard) begin
              discard   <= 1'b0;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end else begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              imem_req    <= 1'b0;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (advance) begin
            instr_valid <= 1'b0;
            if (next_mis) begin
              pc       <= next_al;
              addr_err <= 1'b1;
              halted   <= 1'b1;
              state    <= HALTED;
            end else begin
              pc <= pc_next;
              if (halt) begin
                halted <= 1'b1;
                state  <= HALTED;
              end else begin
                imem_req  <= 1'b1;
                imem_addr <= pc_next;
                state     <= FETCH;
              end
            end
          end
        end
        HALTED: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        halt;
  logic        flush;
  logic [31:0] flush_pc;
  logic        halted;
  logic        addr_err;

  int          checks   = 0;
  int          failures = 0;
  int          mem_lat  = 1;
  int          mem_cnt  = 0;
  logic [31:0] mem_last_addr = 32'hFFFF_FFFF;

  pc_fetch_unit #(.ADDR_BITS(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .pc(pc), .pc_plus4(pc_plus4),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .stall(stall), .halt(halt), .flush(flush),
    .flush_pc(flush_pc), .halted(halted), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2402_0005 : (32'hA500_0000 ^ a);
  endfunction

  // Memory: acks mem_lat cycles after first seeing a request, one cycle wide.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      imem_ack = 1'b0;
      mem_cnt  = 0;
    end else begin
      imem_ack = 1'b0;
      if (imem_req) begin
        if (mem_cnt == mem_lat) begin
          imem_ack      = 1'b1;
          imem_rdata    = mem_data(imem_addr);
          mem_last_addr = imem_addr;
          mem_cnt       = 0;
        end else begin
          mem_cnt++;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, {31'b0, instr_valid}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; pc_next = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; stall = 1'b0; halt = 1'b0; flush = 1'b0; flush_pc = 32'h0;
    tick(); tick();

    // Reset values
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_addr_err", {31'b0, addr_err}, 32'h0);

    // First fetch, 1-cycle memory latency
    rst_n = 1'b1;
    tick();
    check("f1_req", {31'b0, imem_req}, 32'h1);
    check("f1_addr", imem_addr, 32'h0);
    tick();
    check("f1_valid_early", {31'b0, instr_valid}, 32'h0);
    tick();
    check("f1_valid", {31'b0, instr_valid}, 32'h1);
    check("f1_instr", instr, 32'h2402_0005);
    check("f1_plus4", pc_plus4, 32'h4);
    instr_ready = 1'b1; pc_next = 32'h4;
    tick();
    check("adv_pc", pc, 32'h4);
    check("adv_req", {31'b0, imem_req}, 32'h1);
    check("adv_addr", imem_addr, 32'h4);
    check("adv_valid", {31'b0, instr_valid}, 32'h0);
    instr_ready = 1'b0;
    wait_valid("f2_wait");
    check("f2_instr", instr, 32'hA500_0004);

    // Stall for 3 cycles while decode is ready
    instr_ready = 1'b1; stall = 1'b1; pc_next = 32'h40;
    tick(); tick(); tick();
    check("stall_pc", pc, 32'h4);
    check("stall_instr", instr, 32'hA500_0004);
    check("stall_valid", {31'b0, instr_valid}, 32'h1);
    check("stall_req", {31'b0, imem_req}, 32'h0);
    stall = 1'b0;
    tick();
    check("br_pc", pc, 32'h40);
    check("br_addr", imem_addr, 32'h40);
    check("br_req", {31'b0, imem_req}, 32'h1);
    instr_ready = 1'b0;
    wait_valid("br_wait");
    check("br_instr", instr, 32'hA500_0040);

    // Flush one cycle after a request to 0x8, memory acks 3 cycles later
    mem_lat = 3;
    instr_ready = 1'b1; pc_next = 32'h8;
    tick();
    check("fl_req_addr", imem_addr, 32'h8);
    instr_ready = 1'b0; flush = 1'b1; flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    check("fl_pc", pc, 32'h100);
    check("fl_hold_addr1", imem_addr, 32'h8);
    check("fl_hold_req1", {31'b0, imem_req}, 32'h1);
    tick();
    check("fl_hold_addr2", imem_addr, 32'h8);
    tick();
    check("fl_hold_addr3", imem_addr, 32'h8);
    tick();
    check("fl_acked_addr", mem_last_addr, 32'h8);
    check("fl_dropped", {31'b0, instr_valid}, 32'h0);
    check("fl_reissue_req", {31'b0, imem_req}, 32'h1);
    check("fl_reissue_addr", imem_addr, 32'h100);
    wait_valid("fl_wait");
    check("fl_instr", instr, 32'hA500_0100);

    // Flush in the same cycle as the ack
    mem_lat = 1;
    instr_ready = 1'b1; pc_next = 32'h10;
    tick();
    check("fa_addr", imem_addr, 32'h10);
    instr_ready = 1'b0;
    n = 0;
    while (!imem_ack && n < 10) begin
      tick();
      n++;
    end
    flush = 1'b1; flush_pc = 32'h200;
    tick();
    flush = 1'b0;
    check("fa_pc", pc, 32'h200);
    check("fa_addr2", imem_addr, 32'h200);
    check("fa_req", {31'b0, imem_req}, 32'h1);
    check("fa_dropped", {31'b0, instr_valid}, 32'h0);
    tick();
    check("fa_valid_early", {31'b0, instr_valid}, 32'h0);
    tick();
    check("fa_valid", {31'b0, instr_valid}, 32'h1);
    check("fa_instr", instr, 32'hA500_0200);

    // Halt on advance, then ignore flush
    instr_ready = 1'b1; halt = 1'b1; pc_next = 32'h204;
    tick();
    instr_ready = 1'b0; halt = 1'b0;
    check("halt_pc", pc, 32'h204);
    check("halt_flag", {31'b0, halted}, 32'h1);
    check("halt_valid", {31'b0, instr_valid}, 32'h0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) n++;
      tick();
    end
    check("halt_no_req", n, 32'h0);
    flush = 1'b1; flush_pc = 32'h300;
    tick();
    flush = 1'b0;
    check("halt_flush_pc", pc, 32'h204);
    check("halt_flush_req", {31'b0, imem_req}, 32'h0);
    check("halt_still", {31'b0, halted}, 32'h1);
    check("halt_no_err", {31'b0, addr_err}, 32'h0);

    // Reset out of HALTED, then reset again with a request outstanding
    rst_n = 1'b0;
    #1;
    check("ar_halted", {31'b0, halted}, 32'h0);
    check("ar_pc", pc, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_req", {31'b0, imem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("ar_mid_req", {31'b0, imem_req}, 32'h0);
    tick();
    rst_n = 1'b1;
    wait_valid("ar_wait");
    check("ar_instr", instr, 32'h2402_0005);

    // Misaligned pc_next
    instr_ready = 1'b1; pc_next = 32'h6;
    tick();
    instr_ready = 1'b0;
    check("mis_pc", pc, 32'h4);
    check("mis_err", {31'b0, addr_err}, 32'h1);
    check("mis_halted", {31'b0, halted}, 32'h1);
    check("mis_req", {31'b0, imem_req}, 32'h0);

    // pc_plus4 wrap at the top of the address space
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_valid("wr_wait");
    instr_ready = 1'b1; halt = 1'b1; pc_next = 32'hFFFF_FFFC;
    tick();
    instr_ready = 1'b0; halt = 1'b0;
    check("wr_pc", pc, 32'hFFFF_FFFC);
    check("wr_plus4", pc_plus4, 32'h0);
    check("wr_err", {31'b0, addr_err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Sequential consumer of the next-PC value produced by the PC input adapter. It holds the architectural PC register and runs a request/acknowledge fetch from instruction memory. It presents the fetched instruction to decode and advances the PC on a decode handshake. It also handles pipeline flush, stall, halt and misaligned-target detection.

Parameters:
ADDR_BITS, 32, width of PC and instruction-memory address
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_next  input  ADDR_BITS  next PC from the PC input adapter
pc  output  ADDR_BITS  current PC register; feeds the adapter's pc input
pc_plus4  output  ADDR_BITS  combinational pc+4, modulo 2^ADDR_BITS
imem_req  output  1  fetch request, registered
imem_addr  output  ADDR_BITS  fetch address, registered
imem_ack  input  1  memory response valid, one cycle per request
imem_rdata  input  32  instruction word, valid with imem_ack
instr  output  32  captured instruction
instr_valid  output  1  instr holds a live instruction for decode
instr_ready  input  1  decode accepts instr this cycle
stall  input  1  blocks PC advance while high
halt  input  1  sampled at advance; stop fetching after this instruction
flush  input  1  redirect PC to flush_pc
flush_pc  input  ADDR_BITS  redirect target
halted  output  1  unit is in HALTED state
addr_err  output  1  sticky: misaligned pc_next or flush_pc accepted

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC, imem_req=0, imem_addr=0, instr=0, instr_valid=0, halted=0, addr_err=0, discard=0, state=IDLE.
- State IDLE: on the first clk after rst_n rises -> FETCH; imem_req<=1 and imem_addr<=pc.
- State FETCH:
  - imem_req and imem_addr are held stable until imem_ack.
  - On imem_ack with discard=0: instr<=imem_rdata, instr_valid<=1, imem_req<=0 -> HOLD.
  - Minimum latency: request rises at cycle N, ack at cycle N+1 or later, instr_valid rises at the edge after the ack.
- State HOLD: instr_valid=1.
  - Advance when instr_valid && instr_ready && !stall: pc<=pc_next, instr_valid<=0.
  - After advance, if halt -> HALTED (imem_req stays 0). Otherwise -> FETCH with imem_req<=1 and imem_addr<=pc_next in the same edge.
  - stall=1 or instr_ready=0: all registers hold.
- Flush has priority over advance and stall, and is ignored in HALTED.
  - In any state, flush sets pc<=flush_pc and instr_valid<=0.
  - In HOLD or IDLE: -> FETCH, imem_req<=1, imem_addr<=flush_pc.
  - In FETCH without ack this cycle: set discard<=1 and keep the request unchanged. On the later ack, drop the data, clear discard, and reissue the request at the new pc the next cycle (imem_req<=1, imem_addr<=pc).
  - In FETCH with ack in the same cycle: drop the data, then reissue at flush_pc at the same edge.
  - Repeated flushes while discard=1: only the last flush_pc is kept.
- Misalignment: if the value about to load into pc (pc_next or flush_pc) has bits [1:0] != 0:
  - pc loads the value with bits [1:0] forced to 00;
  - addr_err<=1;
  - state -> HALTED; no fetch is issued.
- State HALTED: halted=1, imem_req=0, instr_valid=0, pc frozen. Exit only by reset. A response still outstanding at halt entry cannot occur, because halt is taken only from HOLD.
- pc_plus4 wraps modulo 2^ADDR_BITS; for example 0xFFFF_FFFC maps to 0x0000_0000.
- Reset asserted mid-request: everything returns to its reset values immediately. The memory must tolerate an abandoned request.

Test Plan:
- Reset release, memory acks 1 cycle after the request with 0x2402_0005 -> imem_addr=0x0, instr=0x2402_0005, instr_valid high 2 cycles after request rise. With instr_ready=1 and pc_next=0x4, the next request goes to 0x4.
- instr_valid=1, stall=1 for 3 cycles with instr_ready=1 -> pc and instr hold. On release, pc=pc_next (0x0000_0040 for a branch) and the request goes to 0x40.
- Flush to 0x100 one cycle after a request to 0x8 is issued, memory acks 3 cycles later -> ack data dropped, instr_valid stays 0, imem_addr=0x8 held until ack, then the next request goes to 0x100.
- Flush to 0x200 in the same cycle as imem_ack -> data dropped, next request at 0x200, discard remains 0.
- Advance with halt=1 -> halted=1, imem_req stays 0 for 10 cycles. A later flush is ignored.
- Advance with pc_next=0x0000_0006 -> pc=0x4, addr_err=1, halted=1. pc=0xFFFF_FFFC gives pc_plus4=0x0.
